bus_reader: RTL and testbench

BUS_READER -- requirements
Module: bus_reader

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_index_decoder.sv | 19 +
 rtl/bus_reader.sv | 101 ++++++++++
 tb/tb_bus_reader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared FSM state type and source-index width helper for the bus reader.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // Index 0 is reserved for the pulled-up bus default, so drivers need count+1 codes.
  function automatic int idx_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/bus_index_decoder.sv
// rtl/bus_index_decoder.sv - source index to one-hot driver enable; 0 or out-of-range gives all-zero.
module bus_index_decoder
  import bus_pkg::*;
#(
  parameter int SRC_COUNT = 8,
  parameter int IDX_W     = idx_width(SRC_COUNT)
) (
  input  logic [IDX_W-1:0]     idx_i,
  output logic [SRC_COUNT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      onehot_o[i] = (idx_i == IDX_W'(i + 1));
    end
  end

endmodule

// File: rtl/bus_reader.sv
// rtl/bus_reader.sv - three-phase shared-bus reader loading masked destination registers.
// Optional transfer counter output enabled by defining BUS_READER_COUNT_EN.
module bus_reader
  import bus_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int SRC_COUNT = 8,
  parameter  int DST_COUNT = 8,
  localparam int SRC_IDX_W = idx_width(SRC_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           bus_in,
  input  logic                       req_valid,
  input  logic [SRC_IDX_W-1:0]       req_src,
  input  logic [DST_COUNT-1:0]       req_dst,
  output logic                       req_ready,
  output logic [SRC_COUNT-1:0]       bus_enable,
  output logic [WIDTH*DST_COUNT-1:0] dst_data,
  output logic [DST_COUNT-1:0]       load_strobe,
  output logic                       src_err
`ifdef BUS_READER_COUNT_EN
  , output logic [15:0]              xfer_count
`endif
);

  state_e                     state_q;
  logic [DST_COUNT-1:0]       dst_q;
  logic                       oor_q;
  logic [SRC_COUNT-1:0]       bus_enable_q;
  logic [DST_COUNT-1:0]       load_strobe_q;
  logic [WIDTH*DST_COUNT-1:0] dst_data_q;
  logic                       src_err_q;
  logic [SRC_COUNT-1:0]       src_onehot;
  logic                       src_oor;
`ifdef BUS_READER_COUNT_EN
  logic [15:0]                xfer_count_q;
`endif

  bus_index_decoder #(
    .SRC_COUNT(SRC_COUNT),
    .IDX_W    (SRC_IDX_W)
  ) u_dec (
    .idx_i   (req_src),
    .onehot_o(src_onehot)
  );

  assign src_oor = (req_src > SRC_IDX_W'(SRC_COUNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dst_q         <= '0;
      oor_q         <= 1'b0;
      bus_enable_q  <= '0;
      load_strobe_q <= '0;
      dst_data_q    <= '0;
      src_err_q     <= 1'b0;
`ifdef BUS_READER_COUNT_EN
      xfer_count_q  <= 16'd0;
`endif
    end else begin
      load_strobe_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q      <= DRIVE;
            dst_q        <= req_dst;
            oor_q        <= src_oor;
            bus_enable_q <= src_onehot;
            if (src_oor) src_err_q <= 1'b1;
          end
        end
        DRIVE: state_q <= CAPTURE;
        CAPTURE: begin
          state_q      <= IDLE;
          bus_enable_q <= '0;
          // An errored transfer completes its timing but must not touch any register.
          load_strobe_q <= oor_q ? '0 : dst_q;
          for (int k = 0; k < DST_COUNT; k++) begin
            if (dst_q[k] && !oor_q) dst_data_q[k*WIDTH +: WIDTH] <= bus_in;
          end
`ifdef BUS_READER_COUNT_EN
          xfer_count_q <= xfer_count_q + 16'd1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign bus_enable  = bus_enable_q;
  assign load_strobe = load_strobe_q;
  assign dst_data    = dst_data_q;
  assign src_err     = src_err_q;
`ifdef BUS_READER_COUNT_EN
  assign xfer_count  = xfer_count_q;
`endif

endmodule

// File: tb/tb_bus_reader.sv
// tb/tb_bus_reader.sv - directed self-checking bench for bus_reader (counter test under BUS_READER_COUNT_EN).
module tb_bus_reader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bus_in;
  logic        req_valid;
  logic [3:0]  req_src;
  logic [7:0]  req_dst;
  logic        req_ready;
  logic [7:0]  bus_enable;
  logic [63:0] dst_data;
  logic [7:0]  load_strobe;
  logic        src_err;
`ifdef BUS_READER_COUNT_EN
  logic [15:0] xfer_count;
`endif

  int vectors;
  int miscompares;

  logic [9:0] rdy_log;
  logic [9:0] en_log;
  logic [9:0] stb_log;

  bus_reader #(
    .WIDTH    (8),
    .SRC_COUNT(8),
    .DST_COUNT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .req_valid  (req_valid),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_ready  (req_ready),
    .bus_enable (bus_enable),
    .dst_data   (dst_data),
    .load_strobe(load_strobe),
    .src_err    (src_err)
`ifdef BUS_READER_COUNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; request is presented for exactly one accept edge.
  task automatic xfer(input logic [3:0] src, input logic [7:0] dst, input logic [7:0] bus,
                      input logic [7:0] exp_en, input logic [7:0] exp_stb);
    req_valid = 1'b1;
    req_src   = src;
    req_dst   = dst;
    bus_in    = bus;
    @(negedge clk);
    chk("drive_en", {56'd0, bus_enable}, {56'd0, exp_en});
    chk("drive_rdy", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("capt_en", {56'd0, bus_enable}, {56'd0, exp_en});
    chk("capt_rdy", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("strobe", {56'd0, load_strobe}, {56'd0, exp_stb});
    chk("idle_en", {56'd0, bus_enable}, 64'd0);
    chk("idle_rdy", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    chk("strobe_clr", {56'd0, load_strobe}, 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus_in      = 8'h00;
    req_valid   = 1'b0;
    req_src     = 4'd0;
    req_dst     = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_en", {56'd0, bus_enable}, 64'd0);
    chk("rst_stb", {56'd0, load_strobe}, 64'd0);
    chk("rst_dst", dst_data, 64'd0);
    chk("rst_err", {63'd0, src_err}, 64'd0);
    chk("rst_rdy", {63'd0, req_ready}, 64'd1);
`ifdef BUS_READER_COUNT_EN
    chk("rst_cnt", {48'd0, xfer_count}, 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    xfer(4'd3, 8'b0000_0001, 8'h5A, 8'b0000_0100, 8'h01);
    chk("src3_dst", dst_data, 64'h0000_0000_0000_005A);

    xfer(4'd0, 8'b1000_0001, 8'hFF, 8'h00, 8'h81);
    chk("src0_dst", dst_data, 64'hFF00_0000_0000_00FF);

    xfer(4'd9, 8'b0000_0010, 8'h33, 8'h00, 8'h00);
    chk("oor_dst", dst_data, 64'hFF00_0000_0000_00FF);
    chk("oor_err", {63'd0, src_err}, 64'd1);

    xfer(4'd1, 8'b0000_0100, 8'hC3, 8'h01, 8'h04);
    chk("sticky_err", {63'd0, src_err}, 64'd1);
    chk("src1_dst", dst_data, 64'hFF00_0000_00C3_00FF);

    xfer(4'd8, 8'h00, 8'h11, 8'h80, 8'h00);
    chk("zmask_dst", dst_data, 64'hFF00_0000_00C3_00FF);

    // Back-to-back: valid held high across three transfers.
    req_valid = 1'b1;
    req_src   = 4'd5;
    req_dst   = 8'h08;
    for (int c = 0; c < 10; c++) begin
      if (c == 7) req_valid = 1'b0;
      bus_in     = 8'h10 + 8'(c);
      rdy_log[c] = req_ready;
      en_log[c]  = (bus_enable == 8'h10);
      stb_log[c] = (load_strobe == 8'h08);
      @(negedge clk);
    end
    chk("b2b_rdy", {54'd0, rdy_log}, {54'd0, 10'b10_0100_1001});
    chk("b2b_en", {54'd0, en_log}, {54'd0, 10'b01_1011_0110});
    chk("b2b_stb", {54'd0, stb_log}, {54'd0, 10'b10_0100_1000});
    chk("b2b_dst", dst_data, 64'hFF00_0000_18C3_00FF);

    // Reset asserted while in CAPTURE.
    req_valid = 1'b1;
    req_src   = 4'd2;
    req_dst   = 8'h02;
    bus_in    = 8'hAA;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_en", {56'd0, bus_enable}, 64'h02);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {56'd0, bus_enable}, 64'd0);
    chk("mid_rst_dst", dst_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {63'd0, req_ready}, 64'd1);
    chk("post_rst_dst", dst_data, 64'd0);
    chk("post_rst_stb", {56'd0, load_strobe}, 64'd0);
    chk("post_rst_err", {63'd0, src_err}, 64'd0);

`ifdef BUS_READER_COUNT_EN
    dut.xfer_count_q = 16'hFFFF;
    @(negedge clk);
    chk("cnt_preload", {48'd0, xfer_count}, 64'h0000_0000_0000_FFFF);
    xfer(4'd4, 8'h01, 8'h66, 8'h08, 8'h01);
    chk("cnt_wrap", {48'd0, xfer_count}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
